// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store data memory.
package mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Byte enables across two adjacent words: [3:0] addressed word, [7:4] next word.
  function automatic logic [7:0] byte_en(input size_t sz, input logic [1:0] off);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'b0000_0001;
      SZ_H:    m = 8'b0000_0011;
      SZ_W:    m = 8'b0000_1111;
      default: m = 8'b0000_0000;
    endcase
    return m << off;
  endfunction

  // True when the address is not a multiple of the access size.
  function automatic logic misaligned(input size_t sz, input logic [1:0] off);
    logic m;
    case (sz)
      SZ_H:    m = off[0];
      SZ_W:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Sign/zero extension of right-justified load data.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input size_t sz,
                                               input logic uns);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_B:    r = {{(XLEN-8){d[7] & ~uns}}, d[7:0]};
      SZ_H:    r = {{(XLEN-16){d[15] & ~uns}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
module byte_lane_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic            PC,
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write only the enabled byte lanes; contents survive reset.
  always_ff @(posedge PC) begin
    for (int b = 0; b < DW/8; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory for the load/store path.
// Word-crossing accesses take a second cycle (SPLIT) or are rejected.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter int XLEN           = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                  PC,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err
);
  import mem_pkg::*;

  localparam int WAW = ADDR_WIDTH - 2;

  state_t            state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  // Context held across the two halves of a word-crossing access.
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [1:0]        off_q, off_d;
  size_t             sz_q, sz_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   whi_q, whi_d;
  logic [3:0]        behi_q, behi_d;
  logic [WAW-1:0]    hi_idx_q, hi_idx_d;

  size_t             sz;
  logic [1:0]        off;
  logic [WAW-1:0]    idx;
  logic [7:0]        be8;
  logic              crossing, err, accept;
  logic [2*XLEN-1:0] wd64;
  logic [XLEN-1:0]   split_raw;

  logic [WAW-1:0]    ram_addr;
  logic [3:0]        ram_be;
  logic [XLEN-1:0]   ram_wdata, ram_rdata;

  assign sz        = size_t'(req_size);
  assign off       = req_addr[1:0];
  assign idx       = req_addr[ADDR_WIDTH-1:2];
  assign be8       = byte_en(sz, off);
  assign crossing  = |be8[7:4];
  assign err       = (sz == SZ_ILL) || ((ALLOW_MISALIGN == 0) && misaligned(sz, off));
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  // Store data shifted into its byte lanes across the word pair.
  assign wd64      = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
  // Reassemble a crossing load from the captured low word and the live high word.
  assign split_raw = XLEN'({ram_rdata, lo_q} >> {off_q, 3'b000});

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  byte_lane_ram #(.AW(WAW), .DW(XLEN)) u_ram (
    .PC    (PC),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, RAM port control and response generation.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    lo_d         = lo_q;
    off_d        = off_q;
    sz_d         = sz_q;
    uns_d        = uns_q;
    we_d         = we_q;
    whi_d        = whi_q;
    behi_d       = behi_q;
    hi_idx_d     = hi_idx_q;
    ram_addr     = idx;
    ram_be       = 4'b0000;
    ram_wdata    = wd64[XLEN-1:0];
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            if (req_we) ram_be = be8[3:0];
            if (crossing) begin
              state_d  = SPLIT;
              lo_d     = ram_rdata;
              off_d    = off;
              sz_d     = sz;
              uns_d    = req_unsigned;
              we_d     = req_we;
              whi_d    = wd64[2*XLEN-1:XLEN];
              behi_d   = be8[7:4];
              hi_idx_d = idx + WAW'(1);
            end else begin
              resp_valid_d = 1'b1;
              if (!req_we) resp_rdata_d = load_ext(ram_rdata >> {off, 3'b000}, sz, req_unsigned);
            end
          end
        end
      end
      SPLIT: begin
        ram_addr     = hi_idx_q;
        ram_wdata    = whi_q;
        if (we_q) ram_be = behi_q;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
        if (!we_q) resp_rdata_d = load_ext(split_raw, sz_q, uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset aborts any pending SPLIT silently.
  always_ff @(posedge PC or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      lo_q         <= '0;
      off_q        <= '0;
      sz_q         <= SZ_B;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      whi_q        <= '0;
      behi_q       <= '0;
      hi_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      lo_q         <= lo_d;
      off_q        <= off_d;
      sz_q         <= sz_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      whi_q        <= whi_d;
      behi_q       <= behi_d;
      hi_idx_q     <= hi_idx_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance per misalignment mode (index = ALLOW_MISALIGN).
module tb_data_mem_ctrl;

  logic PC = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       req_valid, req_we, req_unsigned;
  logic [1:0][9:0]  req_addr;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_wdata;
  logic             rdy0, rdy1, rv0, rv1, re0, re1;
  logic [31:0]      rd0, rd1;

  int checks = 0;
  int errors = 0;

  // Byte-level reference memories, one per instance.
  logic [7:0] mem_m [2][1024];

  typedef struct {
    int          s;
    logic        we;
    logic [9:0]  addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tv[$];

  always #5 PC = ~PC;

  data_mem_ctrl #(.ADDR_WIDTH(10), .XLEN(32), .ALLOW_MISALIGN(1)) dut1 (
    .PC(PC), .rst(rst), .req_valid(req_valid[1]), .req_ready(rdy1), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1)
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .XLEN(32), .ALLOW_MISALIGN(0)) dut0 (
    .PC(PC), .rst(rst), .req_valid(req_valid[0]), .req_ready(rdy0), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0)
  );

  function automatic logic get_rv(input int s);
    return (s == 1) ? rv1 : rv0;
  endfunction
  function automatic logic get_rdy(input int s);
    return (s == 1) ? rdy1 : rdy0;
  endfunction
  function automatic logic get_re(input int s);
    return (s == 1) ? re1 : re0;
  endfunction
  function automatic logic [31:0] get_rd(input int s);
    return (s == 1) ? rd1 : rd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: byte-by-byte access on a flat 1 KiB space, addresses wrap.
  task automatic model(input int s, input logic we, input logic [9:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    int a;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a   = int'(addr);
    rd  = '0;
    lat = 1;
    er  = (sz == 2'd3) || (s == 0 && (a % n) != 0);
    if (!er) begin
      if ((a % 4) + n > 4) lat = 2;
      for (int i = 0; i < n; i++) begin
        if (we) mem_m[s][(a + i) % 1024] = wd[8*i +: 8];
        else    rd[8*i +: 8] = mem_m[s][(a + i) % 1024];
      end
      if (!we && !uns && n < 4)
        for (int i = 8*n; i < 32; i++) rd[i] = rd[8*n-1];
    end
  endtask

  // Issue one request (called away from the edge), wait up to 4 cycles for the response.
  task automatic xact(input int s, input logic we, input logic [9:0] addr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output int rlow);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr;
    req_size[s] = sz; req_unsigned[s] = uns; req_wdata[s] = wd;
    @(posedge PC); #1;
    req_valid[s] = 1'b0;
    lat = -1; rlow = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge PC);
      if (get_rv(s)) begin
        lat = c; rd = get_rd(s); er = get_re(s);
        break;
      end
      if (!get_rdy(s)) rlow++;
    end
  endtask

  task automatic run(input int s, input logic we, input logic [9:0] a, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input string tag);
    logic [31:0] mrd, drd;
    logic        mer, der;
    int          mlat, dlat, rl;
    model(s, we, a, sz, uns, wd, mrd, mer, mlat);
    xact(s, we, a, sz, uns, wd, drd, der, dlat, rl);
    check({tag, "_rdata"}, drd, mrd);
    check({tag, "_err"}, 32'(der), 32'(mer));
    check({tag, "_lat"}, dlat, mlat);
  endtask

  function automatic vec_t mk(input int s, input logic we, input logic [9:0] a,
                              input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                              input logic [31:0] erd, input logic eer, input int elat);
    vec_t v;
    v.s = s; v.we = we; v.addr = a; v.sz = sz; v.uns = uns; v.wd = wd;
    v.exp_rd = erd; v.exp_err = eer; v.exp_lat = elat;
    return v;
  endfunction

  initial begin
    logic [31:0] drd, mrd;
    logic        der, mer;
    int          dlat, rl, mlat;

    // Misalign-capable instance.
    tv.push_back(mk(1, 1, 10'h010, 2, 0, 32'hDEADBEEF, 32'h0,        0, 1));
    tv.push_back(mk(1, 0, 10'h010, 2, 0, 32'h0,        32'hDEADBEEF, 0, 1));
    tv.push_back(mk(1, 1, 10'h013, 0, 0, 32'h80,       32'h0,        0, 1));
    tv.push_back(mk(1, 0, 10'h013, 0, 0, 32'h0,        32'hFFFFFF80, 0, 1));
    tv.push_back(mk(1, 0, 10'h013, 0, 1, 32'h0,        32'h00000080, 0, 1));
    tv.push_back(mk(1, 0, 10'h010, 2, 0, 32'h0,        32'h80ADBEEF, 0, 1));
    tv.push_back(mk(1, 1, 10'h022, 2, 0, 32'h11223344, 32'h0,        0, 2));
    tv.push_back(mk(1, 0, 10'h020, 2, 0, 32'h0,        32'h33440000, 0, 1));
    tv.push_back(mk(1, 0, 10'h024, 2, 0, 32'h0,        32'h00001122, 0, 1));
    tv.push_back(mk(1, 0, 10'h022, 2, 0, 32'h0,        32'h11223344, 0, 2));
    tv.push_back(mk(1, 1, 10'h3FE, 2, 0, 32'hAABBCCDD, 32'h0,        0, 2));
    tv.push_back(mk(1, 0, 10'h3FE, 1, 0, 32'h0,        32'hFFFFCCDD, 0, 1));
    tv.push_back(mk(1, 0, 10'h000, 1, 1, 32'h0,        32'h0000AABB, 0, 1));
    tv.push_back(mk(1, 0, 10'h000, 3, 0, 32'h0,        32'h0,        1, 1));
    tv.push_back(mk(1, 1, 10'h003, 1, 0, 32'h00001234, 32'h0,        0, 2));
    tv.push_back(mk(1, 0, 10'h003, 1, 1, 32'h0,        32'h00001234, 0, 2));
    tv.push_back(mk(1, 0, 10'h004, 0, 0, 32'h0,        32'h00000012, 0, 1));
    tv.push_back(mk(1, 0, 10'h001, 1, 0, 32'h0,        32'h000000AA, 0, 1));
    tv.push_back(mk(1, 0, 10'h001, 0, 0, 32'h0,        32'hFFFFFFAA, 0, 1));
    tv.push_back(mk(1, 0, 10'h001, 2, 0, 32'h0,        32'h123400AA, 0, 2));
    // Strict-alignment instance.
    tv.push_back(mk(0, 1, 10'h000, 2, 0, 32'h5A5AA5A5, 32'h0,        0, 1));
    tv.push_back(mk(0, 1, 10'h001, 1, 0, 32'h0000BEEF, 32'h0,        1, 1));
    tv.push_back(mk(0, 0, 10'h000, 2, 0, 32'h0,        32'h5A5AA5A5, 0, 1));
    tv.push_back(mk(0, 0, 10'h000, 3, 0, 32'h0,        32'h0,        1, 1));
    tv.push_back(mk(0, 0, 10'h002, 2, 0, 32'h0,        32'h0,        1, 1));
    tv.push_back(mk(0, 0, 10'h002, 1, 0, 32'h0,        32'h00005A5A, 0, 1));
    tv.push_back(mk(0, 0, 10'h000, 1, 1, 32'h0,        32'h0000A5A5, 0, 1));
    tv.push_back(mk(0, 0, 10'h000, 1, 0, 32'h0,        32'hFFFFA5A5, 0, 1));
    tv.push_back(mk(0, 1, 10'h000, 3, 0, 32'hFFFFFFFF, 32'h0,        1, 1));
    tv.push_back(mk(0, 0, 10'h000, 2, 0, 32'h0,        32'h5A5AA5A5, 0, 1));
    tv.push_back(mk(0, 1, 10'h003, 0, 0, 32'h0000007F, 32'h0,        0, 1));
    tv.push_back(mk(0, 0, 10'h003, 0, 0, 32'h0,        32'h0000007F, 0, 1));
    tv.push_back(mk(0, 0, 10'h000, 2, 0, 32'h0,        32'h7F5AA5A5, 0, 1));

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 1024; a++) mem_m[s][a] = 8'h00;
    req_valid = '0; req_we = '0; req_unsigned = '0;
    req_addr = '0; req_size = '0; req_wdata = '0;

    // Reset state.
    repeat (3) @(posedge PC);
    @(negedge PC);
    check("rst_valid", 32'(rv1), 32'd0);
    check("rst_rdata", rd1, 32'h0);
    check("rst_err", 32'(re1), 32'd0);
    check("rst_ready", 32'(rdy1), 32'd1);
    check("rst_ready0", 32'(rdy0), 32'd1);
    rst = 1'b0;

    // Give both memories known (zero) contents.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 256; w++) begin
        model(s, 1'b1, 10'(w*4), 2'd2, 1'b0, 32'h0, mrd, mer, mlat);
        xact(s, 1'b1, 10'(w*4), 2'd2, 1'b0, 32'h0, drd, der, dlat, rl);
      end

    // Directed vectors.
    foreach (tv[i]) begin
      model(tv[i].s, tv[i].we, tv[i].addr, tv[i].sz, tv[i].uns, tv[i].wd, mrd, mer, mlat);
      xact(tv[i].s, tv[i].we, tv[i].addr, tv[i].sz, tv[i].uns, tv[i].wd, drd, der, dlat, rl);
      check($sformatf("vec%0d_rdata", i), drd, tv[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(der), 32'(tv[i].exp_err));
      check($sformatf("vec%0d_lat", i), dlat, tv[i].exp_lat);
      check($sformatf("vec%0d_ready_low", i), rl, tv[i].exp_lat - 1);
    end

    // Store followed immediately by a load of the same byte.
    model(1, 1'b1, 10'h031, 2'd0, 1'b0, 32'h5C, mrd, mer, mlat);
    model(1, 1'b0, 10'h031, 2'd0, 1'b1, 32'h0, mrd, mer, mlat);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 10'h031;
    req_size[1] = 2'd0; req_unsigned[1] = 1'b0; req_wdata[1] = 32'h5C;
    @(posedge PC); #1;
    req_we[1] = 1'b0; req_unsigned[1] = 1'b1; req_wdata[1] = 32'h0;
    @(negedge PC);
    check("raw_store_valid", 32'(rv1), 32'd1);
    @(posedge PC); #1;
    req_valid[1] = 1'b0;
    @(negedge PC);
    check("raw_load_valid", 32'(rv1), 32'd1);
    check("raw_load_rdata", rd1, 32'h0000005C);
    @(negedge PC);
    check("resp_pulse_width", 32'(rv1), 32'd0);

    // Reset between the two halves of a crossing store.
    xact(1, 1'b1, 10'h020, 2'd2, 1'b0, 32'h0, drd, der, dlat, rl);
    xact(1, 1'b1, 10'h024, 2'd2, 1'b0, 32'hCAFEF00D, drd, der, dlat, rl);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 10'h022;
    req_size[1] = 2'd2; req_unsigned[1] = 1'b0; req_wdata[1] = 32'h11223344;
    @(posedge PC); #1;
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge PC);
    check("abort_valid_in_rst", 32'(rv1), 32'd0);
    @(posedge PC); #1;
    rst = 1'b0;
    @(negedge PC);
    check("abort_valid_after", 32'(rv1), 32'd0);
    check("abort_ready_after", 32'(rdy1), 32'd1);
    xact(1, 1'b0, 10'h020, 2'd2, 1'b0, 32'h0, drd, der, dlat, rl);
    check("abort_low_word", drd, 32'h33440000);
    xact(1, 1'b0, 10'h024, 2'd2, 1'b0, 32'h0, drd, der, dlat, rl);
    check("abort_high_word", drd, 32'hCAFEF00D);
    for (int a = 32; a < 40; a++) mem_m[1][a] = 8'h00;
    mem_m[1][34] = 8'h44; mem_m[1][35] = 8'h33;
    mem_m[1][36] = 8'h0D; mem_m[1][37] = 8'hF0; mem_m[1][38] = 8'hFE; mem_m[1][39] = 8'hCA;

    // Random traffic against the byte-level model, including the top-of-memory wrap.
    for (int k = 0; k < 300; k++) begin
      int          s;
      logic [9:0]  a;
      s = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 63)) : 10'($urandom_range(10'h3F0, 10'h3FF));
      run(s, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Next-generation data memory for the CPU's load/store path: byte-addressed, word-organised, little-endian RAM.
- Supports RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane writes and sign/zero extension.
- Uses a valid/ready request handshake with a registered response.
- Misaligned accesses that cross a word boundary are either split into two word cycles or rejected with an error, selected by parameter.

Parameters:
- ADDR_WIDTH, 10, byte-address width; depth = 2**(ADDR_WIDTH-2) words.
- XLEN, 32, data width; fixed at 32 for this generation.
- ALLOW_MISALIGN, 1, 1 = split word-crossing accesses; 0 = flag any non-naturally-aligned access as an error.

Ports:
- PC  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high iff state==IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and words.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle pulse, response available.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  misalignment or illegal size.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once in IDLE.
  - Memory contents are NOT cleared.
- Handshake:
  - Accept at edge E0 when req_valid && req_ready.
  - No response backpressure.
  - Back-to-back requests are accepted every cycle while in IDLE.
- States: IDLE, SPLIT.
- Aligned (access fits in one word), IDLE path:
  - Array read at E0 (pre-edge contents); extended data registered at E0.
  - resp_valid=1 in the cycle after E0.
  - Stores write only the selected byte lanes at E0.
- Word-crossing access, ALLOW_MISALIGN=1:
  - At E0, low word lanes are written (store) or captured (load); IDLE->SPLIT.
  - In SPLIT, req_ready=0.
  - At E1, high word (index+1, wraps modulo depth) lanes are handled, response registered, SPLIT->IDLE.
  - resp_valid in the cycle after E1.
- ALLOW_MISALIGN=0: any addr not aligned to size → no write; resp_err=1, rdata=0; latency 1.
- req_size=11 → error in both modes; no write.
- Read-after-write: a load accepted the cycle after a store to the same bytes returns the new data.
- Extension: byte/half sign-extend unless req_unsigned; word unchanged.
- Reset during SPLIT:
  - Abort; high-word lanes are not written, low-word writes already committed stay.
  - No response is issued.

Decomposition:
- Package mem_pkg:
  - XLEN constant.
  - size_t enum (SZ_B, SZ_H, SZ_W, SZ_ILL).
  - state_t enum (IDLE, SPLIT).
  - Functions: byte-enable generation from size/offset; load extension.
- Sub-module byte_lane_ram:
  - Word array.
  - 4 per-byte write enables.
  - Asynchronous read port; writes on PC.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → resp_rdata=0xDEADBEEF, resp_valid one cycle after each accept, resp_err=0.
- After the above, SB 0x80 @0x13 → LB @0x13 = 0xFFFFFF80; LBU @0x13 = 0x00000080; LW @0x10 = 0x80ADBEEF.
- ALLOW_MISALIGN=1, zeroed memory: SW 0x11223344 @0x22 → req_ready low one cycle.
  - LW @0x20 = 0x33440000; LW @0x24 = 0x00001122.
  - LW @0x22 = 0x11223344 with response 2 cycles after accept.
- ALLOW_MISALIGN=0: SH 0xBEEF @0x01 → resp_err=1, rdata=0; following LW @0x00 returns the prior value unchanged. LW with req_size=11 → resp_err=1.
- ALLOW_MISALIGN=1, ADDR_WIDTH=10: SW 0xAABBCCDD @0x3FE → LH @0x3FE = 0xFFFFCCDD; LHU @0x000 = 0x0000AABB.
- Assert rst for 1 cycle between E0 and E1 of SW 0x11223344 @0x22:
  - resp_valid stays 0; req_ready=1 after release.
  - LW @0x20 = 0x33440000; LW @0x24 = prior contents.
